ex_operand_stage: RTL and testbench

ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS pipeline. Captures decoded instructions from ID. Resolves `rs`/`rt` operands against the EX/MEM result and the WB write-back data. Drives `alu_a`, `alu_b` and `ex_aluop` directly into the ALU, and the store data into MEM. It also carries the halt marker down the pipe and latches a terminal HALTED state.

---
 rtl/ex_operand_stage_if.sv | 55 +++++
 rtl/ex_operand_stage.sv | 101 ++++++++++
 tb/tb_ex_operand_stage.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs of the operand stage.
// The slave modport is the stage itself; the master modport is whoever drives it.
interface ex_operand_stage_if;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic        id_halt;
    logic        id_alusrc;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic [3:0]  id_aluop;
    logic [31:0] id_pc;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_halt;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic [3:0]  ex_aluop;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_store_data;
    logic        halted;
    logic [31:0] issued_cnt;

    modport master (
        output hold, flush, id_valid, id_halt, id_alusrc, id_regwrite, id_memread, id_memwrite,
               id_aluop, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
        input  ex_valid, ex_halt, ex_regwrite, ex_memread, ex_memwrite, ex_aluop, ex_pc, ex_rd,
               alu_a, alu_b, ex_store_data, halted, issued_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_halt, id_alusrc, id_regwrite, id_memread, id_memwrite,
               id_aluop, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_data,
        output ex_valid, ex_halt, ex_regwrite, ex_memread, ex_memwrite, ex_aluop, ex_pc, ex_rd,
               alu_a, alu_b, ex_store_data, halted, issued_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding from EX/MEM and WB,
// a terminal halt state and a count of issued instructions.
module ex_operand_stage (
    input logic               clk,
    input logic               rst,
    ex_operand_stage_if.slave bus
);
    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e      state_q;
    logic        valid_q, halt_q, alusrc_q, regwrite_q, memread_q, memwrite_q;
    logic [3:0]  aluop_q;
    logic [31:0] pc_q, rs_data_q, rt_data_q, imm_q;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic [31:0] cnt_q;

    logic        load;
    logic        take;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // load: the register is rewritten this edge; take: it is rewritten with the ID fields
    // rather than a bubble.
    assign load = bus.flush || !bus.hold;
    assign take = !bus.flush && !bus.hold && (state_q == StRun);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StRun;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            aluop_q    <= 4'd0;
            pc_q       <= 32'd0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            cnt_q      <= 32'd0;
        end else if (load) begin
            valid_q    <= take && bus.id_valid;
            halt_q     <= take && bus.id_halt;
            alusrc_q   <= take && bus.id_alusrc;
            regwrite_q <= take && bus.id_regwrite;
            memread_q  <= take && bus.id_memread;
            memwrite_q <= take && bus.id_memwrite;
            aluop_q    <= take ? bus.id_aluop   : 4'd0;
            pc_q       <= take ? bus.id_pc      : 32'd0;
            rs_data_q  <= take ? bus.id_rs_data : 32'd0;
            rt_data_q  <= take ? bus.id_rt_data : 32'd0;
            imm_q      <= take ? bus.id_imm     : 32'd0;
            rs_q       <= take ? bus.id_rs      : 5'd0;
            rt_q       <= take ? bus.id_rt      : 5'd0;
            rd_q       <= take ? bus.id_rd      : 5'd0;
            if (take && bus.id_valid) begin
                cnt_q <= cnt_q + 32'd1;
                if (bus.id_halt) begin
                    state_q <= StHalted;
                end
            end
        end
    end

    // EX/MEM is younger than WB, so it wins when both target the same register.
    always_comb begin
        fwd_rs = rs_data_q;
        if (bus.exm_regwrite && (bus.exm_rd != 5'd0) && (bus.exm_rd == rs_q)) begin
            fwd_rs = bus.exm_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs_q)) begin
            fwd_rs = bus.wb_data;
        end
    end

    always_comb begin
        fwd_rt = rt_data_q;
        if (bus.exm_regwrite && (bus.exm_rd != 5'd0) && (bus.exm_rd == rt_q)) begin
            fwd_rt = bus.exm_result;
        end else if (bus.wb_regwrite && (bus.wb_rd != 5'd0) && (bus.wb_rd == rt_q)) begin
            fwd_rt = bus.wb_data;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_halt       = valid_q && halt_q;
    assign bus.ex_regwrite   = valid_q && regwrite_q;
    assign bus.ex_memread    = valid_q && memread_q;
    assign bus.ex_memwrite   = valid_q && memwrite_q;
    assign bus.ex_aluop      = aluop_q & {4{valid_q}};
    assign bus.ex_pc         = pc_q;
    assign bus.ex_rd         = rd_q;
    assign bus.alu_a         = fwd_rs;
    assign bus.alu_b         = alusrc_q ? imm_q : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.halted        = (state_q == StHalted);
    assign bus.issued_cnt    = cnt_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage against a behavioural pipeline model.
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, halt, alusrc, regwrite, memread, memwrite;
        logic [3:0]  aluop;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } instr_t;

    instr_t      m_ex;
    logic        m_halted;
    logic [31:0] m_cnt;
    int          errors = 0;
    int          checks = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{valid: 1'b0, halt: 1'b0, alusrc: 1'b0, regwrite: 1'b0, memread: 1'b0,
              memwrite: 1'b0, aluop: 4'd0, pc: 32'd0, rs_data: 32'd0, rt_data: 32'd0,
              imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        return b;
    endfunction

    // Newest producer first; register 0 is never a forwarding target.
    function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] regv);
        if (bus.exm_regwrite && idx != 0 && bus.exm_rd == idx) return bus.exm_result;
        if (bus.wb_regwrite && idx != 0 && bus.wb_rd == idx) return bus.wb_data;
        return regv;
    endfunction

    task automatic idle_inputs();
        bus.hold = 0; bus.flush = 0;
        bus.id_valid = 0; bus.id_halt = 0; bus.id_alusrc = 0; bus.id_regwrite = 0;
        bus.id_memread = 0; bus.id_memwrite = 0; bus.id_aluop = 0;
        bus.id_pc = 0; bus.id_rs_data = 0; bus.id_rt_data = 0; bus.id_imm = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.exm_regwrite = 0; bus.exm_rd = 0; bus.exm_result = 0;
        bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        m_ex = bubble(); m_halted = 0; m_cnt = 0;
    endtask

    // One clock edge; the model takes the same decision the pipeline should.
    task automatic step();
        @(posedge clk);
        if (bus.flush) m_ex = bubble();
        else if (bus.hold) begin end
        else if (m_halted) m_ex = bubble();
        else begin
            m_ex.valid = bus.id_valid; m_ex.halt = bus.id_halt; m_ex.alusrc = bus.id_alusrc;
            m_ex.regwrite = bus.id_regwrite; m_ex.memread = bus.id_memread;
            m_ex.memwrite = bus.id_memwrite; m_ex.aluop = bus.id_aluop; m_ex.pc = bus.id_pc;
            m_ex.rs_data = bus.id_rs_data; m_ex.rt_data = bus.id_rt_data; m_ex.imm = bus.id_imm;
            m_ex.rs = bus.id_rs; m_ex.rt = bus.id_rt; m_ex.rd = bus.id_rd;
            if (bus.id_valid) begin
                m_cnt = m_cnt + 1;
                if (bus.id_halt) m_halted = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.ex_valid, bus.ex_halt, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
             bus.halted} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 000000",
                {bus.ex_valid, bus.ex_halt, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                 bus.halted});
        end
        checks++;
        if (bus.issued_cnt !== 32'd0 || bus.ex_pc !== 32'd0 || bus.alu_a !== 32'd0 ||
            bus.alu_b !== 32'd0 || bus.ex_store_data !== 32'd0) begin
            errors++; $display("FAIL reset_data: cnt=%h pc=%h a=%h b=%h sd=%h required all 0",
                bus.issued_cnt, bus.ex_pc, bus.alu_a, bus.alu_b, bus.ex_store_data);
        end
    endtask

    task automatic test_passthrough();
        bus.id_valid = 1; bus.id_aluop = 4'h2; bus.id_rs = 1; bus.id_rt = 2; bus.id_rd = 3;
        bus.id_rs_data = 5; bus.id_rt_data = 7; bus.id_pc = 32'h40; bus.id_regwrite = 1;
        step();
        checks++;
        if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
            errors++; $display("FAIL pass_operands: got a=%h b=%h required a=5 b=7",
                bus.alu_a, bus.alu_b);
        end
        checks++;
        if (bus.ex_valid !== 1 || bus.issued_cnt !== 32'd1 || bus.ex_aluop !== 4'h2 ||
            bus.ex_rd !== 5'd3 || bus.ex_pc !== 32'h40) begin
            errors++; $display("FAIL pass_ctrl: got v=%b cnt=%0d op=%h rd=%0d pc=%h required 1 1 2 3 40",
                bus.ex_valid, bus.issued_cnt, bus.ex_aluop, bus.ex_rd, bus.ex_pc);
        end
    endtask

    task automatic test_forward();
        @(negedge clk);
        bus.id_valid = 1; bus.id_alusrc = 0; bus.id_rs = 3; bus.id_rt = 4;
        bus.id_rs_data = 32'hAA; bus.id_rt_data = 32'hBB;
        step();
        bus.id_valid = 0;
        bus.exm_regwrite = 1; bus.exm_rd = 3; bus.exm_result = 32'h11;
        bus.wb_regwrite = 1; bus.wb_rd = 3; bus.wb_data = 32'h22;
        #1; checks++;
        if (bus.alu_a !== 32'h11) begin
            errors++; $display("FAIL fwd_exm_priority: got %h required 11", bus.alu_a);
        end
        bus.exm_regwrite = 0;
        #1; checks++;
        if (bus.alu_a !== 32'h22) begin
            errors++; $display("FAIL fwd_wb: got %h required 22", bus.alu_a);
        end
        bus.wb_rd = 4;
        #1; checks++;
        if (bus.alu_b !== 32'h22 || bus.ex_store_data !== 32'h22 || bus.alu_a !== 32'hAA) begin
            errors++; $display("FAIL fwd_rt_wb: got b=%h sd=%h a=%h required 22 22 AA",
                bus.alu_b, bus.ex_store_data, bus.alu_a);
        end
        @(negedge clk);
        bus.id_valid = 1; bus.id_rs = 0; bus.id_rs_data = 32'h55;
        bus.exm_regwrite = 1; bus.exm_rd = 0; bus.wb_regwrite = 1; bus.wb_rd = 0;
        step();
        checks++;
        if (bus.alu_a !== 32'h55) begin
            errors++; $display("FAIL fwd_r0: got %h required 55", bus.alu_a);
        end
    endtask

    task automatic test_imm();
        @(negedge clk);
        bus.id_valid = 1; bus.id_alusrc = 1; bus.id_imm = 32'h1234; bus.id_rt = 5;
        bus.id_rt_data = 32'h77; bus.exm_regwrite = 1; bus.exm_rd = 5; bus.exm_result = 32'h99;
        step();
        checks++;
        if (bus.alu_b !== 32'h1234 || bus.ex_store_data !== 32'h99) begin
            errors++; $display("FAIL imm_select: got b=%h sd=%h required 1234 99",
                bus.alu_b, bus.ex_store_data);
        end
        bus.id_alusrc = 0;
    endtask

    task automatic test_hold_flush();
        logic [31:0] c0;
        @(negedge clk);
        idle_inputs();
        bus.id_valid = 1; bus.id_regwrite = 1; bus.id_pc = 32'h100;
        step();
        c0 = m_cnt;
        @(negedge clk);
        bus.hold = 1; bus.id_pc = 32'h200; bus.id_rd = 9;
        step(); step();
        checks++;
        if (bus.ex_pc !== 32'h100 || bus.issued_cnt !== c0 || bus.ex_valid !== 1) begin
            errors++; $display("FAIL hold_keep: got pc=%h cnt=%0d v=%b required 100 %0d 1",
                bus.ex_pc, bus.issued_cnt, bus.ex_valid, c0);
        end
        @(negedge clk);
        bus.flush = 1;
        step();
        checks++;
        if (bus.ex_valid !== 0 || bus.ex_regwrite !== 0 || bus.issued_cnt !== c0) begin
            errors++; $display("FAIL flush_hold: got v=%b rw=%b cnt=%0d required 0 0 %0d",
                bus.ex_valid, bus.ex_regwrite, bus.issued_cnt, c0);
        end
        @(negedge clk);
        bus.hold = 0; bus.id_halt = 1;
        step();
        checks++;
        if (bus.halted !== 0 || bus.ex_halt !== 0) begin
            errors++; $display("FAIL flush_halt: got halted=%b ex_halt=%b required 0 0",
                bus.halted, bus.ex_halt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.hold = ($urandom_range(0, 7) == 0); bus.flush = ($urandom_range(0, 7) == 0);
            bus.id_valid = $urandom_range(0, 3) != 0; bus.id_halt = 0;
            bus.id_alusrc = $urandom; bus.id_regwrite = $urandom; bus.id_memread = $urandom;
            bus.id_memwrite = $urandom; bus.id_aluop = 4'($urandom);
            bus.id_pc = $urandom; bus.id_rs_data = $urandom; bus.id_rt_data = $urandom;
            bus.id_imm = $urandom; bus.id_rs = 5'($urandom_range(0, 3));
            bus.id_rt = 5'($urandom_range(0, 3)); bus.id_rd = 5'($urandom);
            step();
            bus.exm_regwrite = $urandom; bus.exm_rd = 5'($urandom_range(0, 3));
            bus.exm_result = $urandom; bus.wb_regwrite = $urandom;
            bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
            #1; checks++;
            if (bus.ex_valid !== m_ex.valid || bus.ex_pc !== m_ex.pc || bus.ex_rd !== m_ex.rd ||
                bus.ex_regwrite !== (m_ex.valid & m_ex.regwrite) ||
                bus.ex_memread !== (m_ex.valid & m_ex.memread) ||
                bus.ex_memwrite !== (m_ex.valid & m_ex.memwrite) ||
                bus.ex_aluop !== (m_ex.valid ? m_ex.aluop : 4'd0) || bus.issued_cnt !== m_cnt) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got v=%b pc=%h rd=%0d op=%h cnt=%0d required v=%b pc=%h rd=%0d op=%h cnt=%0d",
                    i, bus.ex_valid, bus.ex_pc, bus.ex_rd, bus.ex_aluop, bus.issued_cnt,
                    m_ex.valid, m_ex.pc, m_ex.rd, m_ex.aluop, m_cnt);
            end
            checks++;
            if (bus.alu_a !== model_operand(m_ex.rs, m_ex.rs_data) ||
                bus.alu_b !== (m_ex.alusrc ? m_ex.imm : model_operand(m_ex.rt, m_ex.rt_data)) ||
                bus.ex_store_data !== model_operand(m_ex.rt, m_ex.rt_data)) begin
                errors++; $display("FAIL rand_operands[%0d]: got a=%h b=%h sd=%h required a=%h sd=%h",
                    i, bus.alu_a, bus.alu_b, bus.ex_store_data,
                    model_operand(m_ex.rs, m_ex.rs_data), model_operand(m_ex.rt, m_ex.rt_data));
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_halt();
        logic [31:0] c0;
        apply_reset();
        bus.id_valid = 1; bus.id_halt = 1; bus.id_pc = 32'h300;
        step();
        checks++;
        if (bus.ex_halt !== 1 || bus.halted !== 1 || bus.issued_cnt !== 32'd1) begin
            errors++; $display("FAIL halt_enter: got ex_halt=%b halted=%b cnt=%0d required 1 1 1",
                bus.ex_halt, bus.halted, bus.issued_cnt);
        end
        c0 = m_cnt;
        @(negedge clk);
        bus.id_halt = 0; bus.id_pc = 32'h304;
        step();
        checks++;
        if (bus.ex_halt !== 0 || bus.ex_valid !== 0 || bus.halted !== 1 || bus.issued_cnt !== c0) begin
            errors++; $display("FAIL halt_stay: got ex_halt=%b v=%b halted=%b cnt=%0d required 0 0 1 %0d",
                bus.ex_halt, bus.ex_valid, bus.halted, bus.issued_cnt, c0);
        end
        step();
        checks++;
        if (bus.ex_valid !== 0 || bus.halted !== 1) begin
            errors++; $display("FAIL halt_blocks: got v=%b halted=%b required 0 1",
                bus.ex_valid, bus.halted);
        end
        #2 rst = 1;
        #1 checks++;
        if (bus.halted !== 0 || bus.issued_cnt !== 32'd0) begin
            errors++; $display("FAIL async_reset: got halted=%b cnt=%0d required 0 0",
                bus.halted, bus.issued_cnt);
        end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        m_ex = bubble(); m_halted = 0; m_cnt = 0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1 release dut.cnt_q;
        bus.id_valid = 1;
        step();
        checks++;
        if (bus.issued_cnt !== 32'd0) begin
            errors++; $display("FAIL cnt_wrap: got %h required 00000000", bus.issued_cnt);
        end
        @(negedge clk);
        bus.flush = 1;
        step();
        checks++;
        if (bus.issued_cnt !== 32'd0 || bus.ex_valid !== 0) begin
            errors++; $display("FAIL cnt_after_wrap: got cnt=%h v=%b required 0 0",
                bus.issued_cnt, bus.ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_forward();
        test_imm();
        test_hold_flush();
        test_random();
        test_halt();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
